// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner selection for the shared 12-bit hex display.
// Each grant latches one requester's value and holds it for at least HOLD_CYCLES
// clocks; the last value stays on the display while nobody is asking.
module display_arbiter #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  req,
    input  logic [47:0] req_data,
    output logic [3:0]  ack,
    output logic [11:0] disp_data,
    output logic [1:0]  disp_src,
    output logic        disp_valid,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         last_src_q, last_src_d;
    logic [3:0]         ack_q, ack_d;
    logic [11:0]        disp_data_q, disp_data_d;
    logic [1:0]         disp_src_q, disp_src_d;
    logic               disp_valid_q, disp_valid_d;
    logic               busy_q, busy_d;

    logic               win_found_s;
    logic [1:0]         win_idx_s;
    logic [1:0]         cand_s;
    logic               grant_s;

    // Round-robin search: first requester after last_src, wrapping modulo 4.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand_s = last_src_q + 2'(k);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state logic: hold-window countdown and grant events.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_src_d   = last_src_q;
        ack_d        = 4'b0000;
        disp_data_d  = disp_data_q;
        disp_src_d   = disp_src_q;
        disp_valid_d = disp_valid_q;
        busy_d       = busy_q;
        grant_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
            end
            HOLD: begin
                // cnt == 0 is resolved before any decrement, so cnt cannot wrap.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (req != 4'b0000) begin
                    grant_s = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (grant_s && win_found_s) begin
            ack_d        = 4'b0001 << win_idx_s;
            disp_data_d  = req_data[12*win_idx_s +: 12];
            disp_src_d   = win_idx_s;
            last_src_d   = win_idx_s;
            disp_valid_d = 1'b1;
            busy_d       = 1'b1;
            cnt_d        = CNT_W'(HOLD_CYCLES - 1);
            state_d      = HOLD;
        end else begin
            ack_d = 4'b0000;
        end
    end

    // State and output registers; clr acts immediately, also cutting an ack pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_src_q   <= 2'd3;
            ack_q        <= 4'b0000;
            disp_data_q  <= 12'h000;
            disp_src_q   <= 2'd0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_src_q   <= last_src_d;
            ack_q        <= ack_d;
            disp_data_q  <= disp_data_d;
            disp_src_q   <= disp_src_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign disp_data  = disp_data_q;
    assign disp_src   = disp_src_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter: directed scenarios followed by randomized
// requesters, all checked against a timestamp-based reference model.
module tb_display_arbiter;

    localparam int H = 4;

    logic        clk;
    logic        clr;
    logic [3:0]  req;
    logic [47:0] req_data;
    logic [3:0]  ack;
    logic [11:0] disp_data;
    logic [1:0]  disp_src;
    logic        disp_valid;
    logic        busy;

    int n_checks;
    int n_errors;

    // Reference model: a grant may happen at edge e whenever e >= next_opp;
    // the display is busy for edges g .. g+H-1 after a grant at edge g.
    int          m_cyc;
    int          m_next_opp;
    int          m_busy_until;
    int          m_last;
    logic [3:0]  m_ack;
    logic [11:0] m_data;
    logic [1:0]  m_src;
    logic        m_valid;
    logic        m_busy;

    int g_src[$];
    int g_edge[$];

    display_arbiter #(.HOLD_CYCLES(H), .CNT_W(3)) dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .disp_data  (disp_data),
        .disp_src   (disp_src),
        .disp_valid (disp_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_next_opp   = 0;
        m_busy_until = -1;
        m_last       = 3;
        m_ack        = 4'b0000;
        m_data       = 12'h000;
        m_src        = 2'd0;
        m_valid      = 1'b0;
        m_busy       = 1'b0;
    endtask

    task automatic model_step();
        int w;
        m_cyc++;
        m_ack = 4'b0000;
        w = -1;
        if (m_cyc >= m_next_opp) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (w < 0 && req[c]) w = c;
            end
        end
        if (w >= 0) begin
            m_ack        = 4'(1 << w);
            m_data       = req_data[12*w +: 12];
            m_src        = 2'(w);
            m_last       = w;
            m_valid      = 1'b1;
            m_next_opp   = m_cyc + H;
            m_busy_until = m_cyc + H - 1;
        end
        m_busy = (m_cyc <= m_busy_until);
    endtask

    task automatic check_all();
        chk_eq("ack",        48'(ack),        48'(m_ack));
        chk_eq("disp_data",  48'(disp_data),  48'(m_data));
        chk_eq("disp_src",   48'(disp_src),   48'(m_src));
        chk_eq("disp_valid", 48'(disp_valid), 48'(m_valid));
        chk_eq("busy",       48'(busy),       48'(m_busy));
    endtask

    // One clock: model follows the edge, outputs are compared at the negedge.
    task automatic cycle();
        @(posedge clk);
        if (clr) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
        for (int i = 0; i < 4; i++) begin
            if (!clr && ack[i]) begin
                g_src.push_back(i);
                g_edge.push_back(m_cyc);
            end
        end
    endtask

    // Clock n cycles with well-behaved requesters that drop req after their ack.
    task automatic run(input int n);
        for (int j = 0; j < n; j++) begin
            cycle();
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) req[i] = 1'b0;
            end
        end
    endtask

    task automatic clear_log();
        g_src.delete();
        g_edge.delete();
    endtask

    // Asynchronous clear applied between edges, held across one rising edge.
    task automatic async_clr(input string tag);
        clr = 1'b1;
        #1;
        model_reset();
        chk_eq({tag, "_ack_now"},   48'(ack),        48'(4'b0000));
        chk_eq({tag, "_valid_now"}, 48'(disp_valid), 48'(1'b0));
        chk_eq({tag, "_busy_now"},  48'(busy),       48'(1'b0));
        chk_eq({tag, "_data_now"},  48'(disp_data),  48'(12'h000));
        chk_eq({tag, "_src_now"},   48'(disp_src),   48'(2'd0));
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_cyc    = 0;
        clr      = 1'b1;
        req      = 4'b0000;
        req_data = 48'h0;
        model_reset();
        #1;
        check_all();
        cycle();
        clr = 1'b0;

        // Single request from requester 1.
        req_data[23:12] = 12'hABC;
        req = 4'b0010;
        run(1);
        chk_eq("s1_ack",   48'(ack),       48'(4'b0010));
        chk_eq("s1_data",  48'(disp_data), 48'(12'hABC));
        chk_eq("s1_src",   48'(disp_src),  48'(2'd1));
        chk_eq("s1_valid", 48'(disp_valid), 48'(1'b1));
        run(3);
        chk_eq("s1_busy_last", 48'(busy), 48'(1'b1));
        run(1);
        chk_eq("s1_busy_off",  48'(busy), 48'(1'b0));
        chk_eq("s1_data_kept", 48'(disp_data), 48'(12'hABC));

        // All four requesting; round robin from requester 0 (pointer was 1 -> starts at 2).
        // Reset the pointer first so requester 0 has first priority.
        async_clr("pre_s2");
        for (int i = 0; i < 4; i++) req_data[12*i +: 12] = 12'(12'h100 * (i + 1));
        req = 4'b1111;
        clear_log();
        run(17);
        chk_eq("s2_ngrants", 48'(g_src.size()), 48'(4));
        for (int i = 0; i < 4 && i < g_src.size(); i++) begin
            chk_eq("s2_order", 48'(g_src[i]), 48'(i));
            if (i > 0) chk_eq("s2_spacing", 48'(g_edge[i] - g_edge[i-1]), 48'(H));
        end
        chk_eq("s2_last_data", 48'(disp_data), 48'(12'h400));

        // Fairness: grant to 2, then 3 and 0 request together.
        req = 4'b0100;
        run(5);
        req = 4'b1001;
        clear_log();
        run(10);
        chk_eq("s3_ngrants", 48'(g_src.size()), 48'(2));
        if (g_src.size() == 2) begin
            chk_eq("s3_first",   48'(g_src[0]), 48'(3));
            chk_eq("s3_second",  48'(g_src[1]), 48'(0));
            chk_eq("s3_spacing", 48'(g_edge[1] - g_edge[0]), 48'(H));
        end

        // Late arrival of req0 and a withdrawn req1 pulse inside the hold window.
        req = 4'b0100;
        clear_log();
        run(1);
        req[0] = 1'b1;
        req[1] = 1'b1;
        run(2);
        req[1] = 1'b0;
        run(6);
        chk_eq("s4_ngrants", 48'(g_src.size()), 48'(2));
        if (g_src.size() == 2) begin
            chk_eq("s4_first",  48'(g_src[0]), 48'(2));
            chk_eq("s4_second", 48'(g_src[1]), 48'(0));
            chk_eq("s4_delay",  48'(g_edge[1] - g_edge[0]), 48'(H));
        end

        // Clear in the middle of a hold window while ack is high.
        req = 4'b1000;
        run(1);
        chk_eq("s5_ack3", 48'(ack), 48'(4'b1000));
        async_clr("s5");
        req = 4'b1111;
        run(1);
        chk_eq("s5_ack0",  48'(ack),        48'(4'b0001));
        chk_eq("s5_valid", 48'(disp_valid), 48'(1'b1));
        req = 4'b0000;
        run(6);

        // Randomized requesters with occasional withdrawals, data churn and clears.
        for (int n = 0; n < 3000; n++) begin
            cycle();
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 7) != 0) req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[12*i +: 12] = 12'($urandom);
                end else begin
                    req_data[12*i +: 12] = 12'($urandom);
                end
            end
            if ($urandom_range(0, 399) == 0) async_clr("rnd_clr");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
